instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline; drives the IF/ID register that feeds decode.
//  Holds the PC and a word-addressed instruction memory loaded through a program port.
//  Registers {PC+4, instruction} into IF/ID every enabled cycle.
//  Applies the redirects and stall requests that decode and execute send back.
// PARAMETERS
//  len      32    datapath / instruction width
//  depth    1024  instruction memory depth in words
//  NB_addr  $clog2(depth)  word-index width
// PORTS
//  clk                   in   1        rising-edge clock, sole clock
//  reset                 in   1        synchronous, active-high
//  enable                in   1        run enable; 0 freezes PC and IF/ID
//  stall_flag            in   1        load-use stall from decode hazard unit
//  flag_branch           in   1        taken branch resolved downstream
//  in_pc_branch          in   len      branch target
//  flag_jump             in   1        J/JAL decoded in ID
//  in_pc_jump            in   len      jump target
//  flag_jump_register    in   1        JR/JALR decoded in ID
//  in_pc_jump_register   in   len      register jump target
//  prog_wr_en            in   1        program-load write strobe
//  prog_addr             in   NB_addr  program-load word index
//  prog_data             in   len      program-load word
//  out_pc_branch         out  len      IF/ID PC+4 of fetched instruction
//  out_instruccion       out  len      IF/ID instruction
//  out_halt              out  1        halt detected (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: pc=0, out_pc_branch=0, out_instruccion=0 (NOP), out_halt=0; memory not cleared.
//  - Fetch: on an enabled, unstalled edge: out_instruccion<=mem[pc[NB_addr+1:2]], out_pc_branch<=pc+4, pc<=next_pc.
//    One-cycle latency from PC value to IF/ID.
//  - Word index = pc[NB_addr+1:2]; upper bits and pc[1:0] ignored (wraps modulo depth).
//  - next_pc priority: flag_branch > flag_jump_register > flag_jump > pc+4. Arithmetic is mod 2^32.
//  - Redirect (any taken flag): pc<=target and out_instruccion<=0, out_pc_branch<=0 (flush wrong path). No delay slot.
//  - Stall (stall_flag=1, no flag_branch): pc, out_pc_branch, out_instruccion hold.
//    flag_jump and flag_jump_register are ignored while stalled.
//  - Stall + flag_branch on the same edge: the branch wins (redirect and flush).
//  - enable=0: all state holds, redirects and stalls are ignored, and the program port is active.
//    On a prog_wr_en edge: mem[prog_addr]<=prog_data.
//    prog_wr_en while enable=1 is ignored.
//  - reset has priority over every other input, including mid-stall and mid-load.
// CONFIGURATION
//  FETCH_HALT_EN defined:
//   - A fetched word 32'hFFFFFFFF sets sticky out_halt on that edge and is registered as NOP.
//   - While out_halt=1, pc and IF/ID freeze.
//   - out_halt clears only on reset.
//  FETCH_HALT_EN undefined: out_halt tied 0; 32'hFFFFFFFF is fetched as an ordinary word.
// TESTING
//  1 Load mem[0..3]=A,B,C,D, reset, enable=1 -> IF/ID: (4,A),(8,B),(12,C),(16,D) on consecutive cycles.
//  2 stall_flag=1 for 2 cycles after fetching B -> IF/ID holds (8,B) two cycles, then (12,C).
//  3 flag_jump=1, in_pc_jump=0x40 -> next IF/ID=(0,0); following=(0x44,mem[16]).
//  4 stall_flag=1 + flag_branch=1, in_pc_branch=0x20, flag_jump=1 -> pc=0x20, IF/ID flushed to 0.
//  5 enable=1, prog_wr_en writes mem[0]=X -> mem[0] unchanged; enable=0 write -> reset/enable fetches X.
//  6 FETCH_HALT_EN, mem[2]=FFFFFFFF -> out_halt=1 at third fetch, IF/ID=(0,0)... frozen until reset.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage: PC, word-addressed instruction memory with a program-load port,
// and the IF/ID register {PC+4, instruction} feeding decode.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   enable                run enable; 0 freezes state and opens the program port
//   stall_flag            load-use stall (hold PC and IF/ID)
//   flag_branch / in_pc_branch                taken branch redirect
//   flag_jump_register / in_pc_jump_register  JR/JALR redirect
//   flag_jump / in_pc_jump                    J/JAL redirect
//   prog_wr_en, prog_addr, prog_data          program-load write port
//   out_pc_branch, out_instruccion            IF/ID register
//   out_halt              sticky halt flag
//
// Optional feature: define FETCH_HALT_EN to treat 32'hFFFFFFFF as a halt word.
module instruction_fetch #(
   parameter int len     = 32,
   parameter int depth   = 1024,
   parameter int NB_addr = $clog2(depth)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               stall_flag,
   input  logic               flag_branch,
   input  logic [len-1:0]     in_pc_branch,
   input  logic               flag_jump,
   input  logic [len-1:0]     in_pc_jump,
   input  logic               flag_jump_register,
   input  logic [len-1:0]     in_pc_jump_register,
   input  logic               prog_wr_en,
   input  logic [NB_addr-1:0] prog_addr,
   input  logic [len-1:0]     prog_data,
   output logic [len-1:0]     out_pc_branch,
   output logic [len-1:0]     out_instruccion,
   output logic               out_halt
);

   logic [len-1:0] mem_q [depth];
   logic [len-1:0] pc_q;
   logic [len-1:0] ifid_pc_q;
   logic [len-1:0] ifid_ins_q;
   logic [len-1:0] fetch_w;
   logic [len-1:0] pc_plus4;
   logic           halt_q;

   // Word index drops byte offset; upper PC bits wrap modulo depth.
   assign fetch_w  = mem_q[pc_q[NB_addr+1:2]];
   assign pc_plus4 = pc_q + len'(4);

   // Memory is never cleared; writes only while the core is not running.
   always_ff @(posedge clk) begin
      if (!reset && !enable && prog_wr_en)
         mem_q[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= '0;
         ifid_pc_q  <= '0;
         ifid_ins_q <= '0;
         halt_q     <= 1'b0;
      end else if (!enable || halt_q) begin
         pc_q <= pc_q;
      end else if (flag_branch) begin
         // Branch beats a simultaneous stall: redirect and flush.
         pc_q       <= in_pc_branch;
         ifid_pc_q  <= '0;
         ifid_ins_q <= '0;
      end else if (stall_flag) begin
         pc_q <= pc_q;
      end else if (flag_jump_register) begin
         pc_q       <= in_pc_jump_register;
         ifid_pc_q  <= '0;
         ifid_ins_q <= '0;
      end else if (flag_jump) begin
         pc_q       <= in_pc_jump;
         ifid_pc_q  <= '0;
         ifid_ins_q <= '0;
      end else begin
`ifdef FETCH_HALT_EN
         if (fetch_w == {len{1'b1}}) begin
            // Halt word becomes a NOP; PC stays on it.
            halt_q     <= 1'b1;
            ifid_pc_q  <= '0;
            ifid_ins_q <= '0;
         end else begin
            pc_q       <= pc_plus4;
            ifid_pc_q  <= pc_plus4;
            ifid_ins_q <= fetch_w;
         end
`else
         pc_q       <= pc_plus4;
         ifid_pc_q  <= pc_plus4;
         ifid_ins_q <= fetch_w;
`endif
      end
   end

   assign out_pc_branch   = ifid_pc_q;
   assign out_instruccion = ifid_ins_q;
`ifdef FETCH_HALT_EN
   assign out_halt = halt_q;
`else
   assign out_halt = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: reference model checked every cycle
// plus directed literal expectations.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset, enable, stall_flag;
   logic        flag_branch, flag_jump, flag_jump_register;
   logic [31:0] in_pc_branch, in_pc_jump, in_pc_jump_register;
   logic        prog_wr_en;
   logic [9:0]  prog_addr;
   logic [31:0] prog_data;
   logic [31:0] out_pc_branch, out_instruccion;
   logic        out_halt;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [31:0] A = 32'hAAAA0001;
   localparam logic [31:0] B = 32'hBBBB0002;
   localparam logic [31:0] C = 32'hCCCC0003;
   localparam logic [31:0] D = 32'hDDDD0004;
   localparam logic [31:0] X = 32'h12345678;
   localparam logic [31:0] Y = 32'h0BADF00D;
   localparam logic [31:0] H = 32'hFFFFFFFF;

   instruction_fetch dut (
      .clk(clk), .reset(reset), .enable(enable),
      .stall_flag(stall_flag),
      .flag_branch(flag_branch), .in_pc_branch(in_pc_branch),
      .flag_jump(flag_jump), .in_pc_jump(in_pc_jump),
      .flag_jump_register(flag_jump_register),
      .in_pc_jump_register(in_pc_jump_register),
      .prog_wr_en(prog_wr_en), .prog_addr(prog_addr),
      .prog_data(prog_data),
      .out_pc_branch(out_pc_branch),
      .out_instruccion(out_instruccion),
      .out_halt(out_halt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(int i);
      return 32'hC0000000 | 32'(i);
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] m_mem [1024];
   logic [31:0] m_pc, m_pcb, m_ins;
   logic        m_halt;
   bit          m_valid = 0;

   always @(posedge clk) begin
      logic [31:0] w;
      logic [31:0] tgt;
      bit          redirect;
      redirect = 0;
      tgt      = 0;
      if (reset) begin
         m_pc = 0; m_pcb = 0; m_ins = 0; m_halt = 0;
         m_valid = 1;
      end else if (!enable) begin
         if (prog_wr_en) m_mem[prog_addr] = prog_data;
      end else if (!m_halt) begin
         if (flag_branch) begin
            redirect = 1; tgt = in_pc_branch;
         end else if (!stall_flag) begin
            if (flag_jump_register) begin
               redirect = 1; tgt = in_pc_jump_register;
            end else if (flag_jump) begin
               redirect = 1; tgt = in_pc_jump;
            end
         end
         if (redirect) begin
            m_pc = tgt; m_pcb = 0; m_ins = 0;
         end else if (!stall_flag) begin
            w = m_mem[(m_pc / 4) % 1024];
`ifdef FETCH_HALT_EN
            if (w == 32'hFFFFFFFF) begin
               m_halt = 1; m_pcb = 0; m_ins = 0;
            end else begin
               m_ins = w; m_pc = m_pc + 4; m_pcb = m_pc;
            end
`else
            m_ins = w; m_pc = m_pc + 4; m_pcb = m_pc;
`endif
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         n_checks++;
         if (out_pc_branch === m_pcb && out_instruccion === m_ins &&
             out_halt === m_halt)
            n_pass++;
         else
            $display("FAIL model t=%0t got pc=%h ins=%h halt=%b want pc=%h ins=%h halt=%b",
                     $time, out_pc_branch, out_instruccion, out_halt,
                     m_pcb, m_ins, m_halt);
      end
   end

   // ---------------- literal expectations ----------------
   task automatic lit(string nm, logic [31:0] pcb, logic [31:0] ins, logic h);
      n_checks++;
      if (out_pc_branch === pcb && out_instruccion === ins && out_halt === h)
         n_pass++;
      else
         $display("FAIL %s got pc=%h ins=%h halt=%b want pc=%h ins=%h halt=%b",
                  nm, out_pc_branch, out_instruccion, out_halt, pcb, ins, h);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle();
      stall_flag = 0; flag_branch = 0; flag_jump = 0;
      flag_jump_register = 0; prog_wr_en = 0;
   endtask

   task automatic load(int a, logic [31:0] d);
      prog_wr_en = 1; prog_addr = 10'(a); prog_data = d;
      tick();
      prog_wr_en = 0;
   endtask

   task automatic restart();
      enable = 0; reset = 1;
      tick();
      reset = 0; enable = 1;
   endtask

   initial begin
      reset = 1; enable = 0; idle();
      in_pc_branch = 0; in_pc_jump = 0; in_pc_jump_register = 0;
      prog_addr = 0; prog_data = 0;
      tick();
      lit("reset", 32'h0, 32'h0, 1'b0);
      reset = 0;

      for (int i = 0; i < 64; i++) load(i, pat(i));
      load(0, A); load(1, B); load(2, C); load(3, D);
      load(1023, pat(1023));

      // sequential fetch and load-use stall
      restart();
      tick(); lit("fetch0", 32'd4, A, 0);
      tick(); lit("fetch1", 32'd8, B, 0);
      stall_flag = 1;
      tick(); lit("stall1", 32'd8, B, 0);
      tick(); lit("stall2", 32'd8, B, 0);
      stall_flag = 0;
      tick(); lit("fetch2", 32'd12, C, 0);
      tick(); lit("fetch3", 32'd16, D, 0);

      // jump flush, no delay slot
      flag_jump = 1; in_pc_jump = 32'h40;
      tick(); lit("jflush", 32'h0, 32'h0, 0);
      flag_jump = 0;
      tick(); lit("jtgt", 32'h44, pat(16), 0);

      // stall + branch + jump: branch wins
      stall_flag = 1; flag_branch = 1; in_pc_branch = 32'h20; flag_jump = 1;
      tick(); lit("bflush", 32'h0, 32'h0, 0);
      idle();
      tick(); lit("btgt", 32'h24, pat(8), 0);

      // JR beats J
      flag_jump_register = 1; in_pc_jump_register = 32'h10;
      flag_jump = 1; in_pc_jump = 32'h80;
      tick();
      idle();
      tick(); lit("jrtgt", 32'h14, pat(4), 0);

      // jump ignored while stalled
      stall_flag = 1; flag_jump = 1; in_pc_jump = 32'h80;
      tick(); lit("jstall", 32'h14, pat(4), 0);
      idle();
      tick(); lit("jstall2", 32'h18, pat(5), 0);

      // enable=0 ignores redirects
      enable = 0; flag_branch = 1; in_pc_branch = 32'h100;
      tick(); tick(); lit("frozen", 32'h18, pat(5), 0);
      idle(); enable = 1;
      tick(); lit("resume", 32'h1C, pat(6), 0);

      // index wraps modulo depth, low bits ignored
      flag_jump = 1; in_pc_jump = 32'h1002;
      tick(); idle();
      tick(); lit("wrap", 32'h1006, A, 0);
      flag_jump = 1; in_pc_jump = 32'hFFFFFFFC;
      tick(); idle();
      tick(); lit("pc32wrap", 32'h0, pat(1023), 0);

      // program port ignored while running
      prog_wr_en = 1; prog_addr = 0; prog_data = X;
      tick(); prog_wr_en = 0;
      restart();
      tick(); lit("nowrite", 32'd4, A, 0);

      // write while idle takes effect; reset blocks a write
      enable = 0;
      load(0, X);
      reset = 1; prog_wr_en = 1; prog_addr = 1; prog_data = Y;
      tick();
      idle(); reset = 0; enable = 1;
      tick(); lit("loadX", 32'd4, X, 0);
      tick(); lit("rstload", 32'd8, B, 0);

      // halt word
      enable = 0;
      load(2, H);
      restart();
      tick(); tick();
`ifdef FETCH_HALT_EN
      tick(); lit("halt", 32'h0, 32'h0, 1);
      flag_branch = 1; in_pc_branch = 32'h40;
      tick(); tick(); lit("haltfrz", 32'h0, 32'h0, 1);
      idle();
`else
      tick(); lit("nohalt", 32'd12, H, 0);
      tick(); lit("nohalt2", 32'd16, D, 0);
`endif
      reset = 1;
      tick(); lit("rsthalt", 32'h0, 32'h0, 0);
      reset = 0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
